// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO sizing defaults used by the controller and the FIFO memory block,
// plus a legality check for controller parameter sets.
package fifo_ctrl_pkg;

    localparam int FDEPTH_DEF  = 8;
    localparam int FCWIDTH_DEF = 3;
    localparam int FWIDTH_DEF  = 8;
    localparam int AFULL_DEF   = 6;
    localparam int AEMPTY_DEF  = 2;

    function automatic bit params_ok(input int depth, input int cw,
                                     input int afull, input int aempty);
        return (depth >= 2) && ((1 << cw) >= depth) &&
               (aempty < afull) && (afull <= depth);
    endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping modulo-DEPTH address pointer with increment and synchronous clear.
module fifo_ptr_ctr #(
    parameter int DEPTH = 8,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            // Explicit wrap so non-power-of-two depths never visit unused slots
            ptr_d = (ptr_q == W'(DEPTH - 1)) ? '0 : ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO sequencing: accepts active-low read/write requests, drives the memory
// write strobe and addresses, and keeps occupancy, status flags and sticky errors.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int FDEPTH     = FDEPTH_DEF,
    parameter int FCWIDTH    = FCWIDTH_DEF,
    parameter int AFULL_LVL  = AFULL_DEF,
    parameter int AEMPTY_LVL = AEMPTY_DEF
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               writeN,
    input  logic               readN,
    input  logic               clrN,
    output logic               mem_writeN,
    output logic [FCWIDTH-1:0] wr_addr,
    output logic [FCWIDTH-1:0] rd_addr,
    output logic [FCWIDTH:0]   fcount,
    output logic               F_EmptyN,
    output logic               F_FullN,
    output logic               F_AEmptyN,
    output logic               F_AFullN,
    output logic               ovfl,
    output logic               udfl
);

    localparam int                CW       = FCWIDTH + 1;
    localparam logic [FCWIDTH:0]  DEPTH_C  = CW'(FDEPTH);
    localparam logic [FCWIDTH:0]  AFULL_C  = CW'(AFULL_LVL);
    localparam logic [FCWIDTH:0]  AEMPTY_C = CW'(AEMPTY_LVL);

    generate
        if (!params_ok(FDEPTH, FCWIDTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
            $error("fifo_ctrl: illegal FDEPTH/FCWIDTH/AFULL_LVL/AEMPTY_LVL combination");
        end
    endgenerate

    logic             clr;
    logic             rd_acc;
    logic             wr_acc;
    logic [FCWIDTH:0] fcount_q, fcount_d;
    logic             empty_n_q, empty_n_d;
    logic             full_n_q, full_n_d;
    logic             aempty_n_q, aempty_n_d;
    logic             afull_n_q, afull_n_d;
    logic             ovfl_q, ovfl_d;
    logic             udfl_q, udfl_d;

    assign clr    = !clrN;
    assign rd_acc = !readN && (fcount_q != '0);
    // A read in the same cycle frees the slot, so a full FIFO still takes the write
    assign wr_acc = !writeN && ((fcount_q != DEPTH_C) || rd_acc);

    assign mem_writeN = !(wr_acc && rstN && clrN);

    fifo_ptr_ctr #(.DEPTH(FDEPTH), .W(FCWIDTH)) u_wr_ptr (
        .clk  (clk),
        .rstN (rstN),
        .clr  (clr),
        .inc  (wr_acc),
        .ptr  (wr_addr)
    );

    fifo_ptr_ctr #(.DEPTH(FDEPTH), .W(FCWIDTH)) u_rd_ptr (
        .clk  (clk),
        .rstN (rstN),
        .clr  (clr),
        .inc  (rd_acc),
        .ptr  (rd_addr)
    );

    always_comb begin
        fcount_d = fcount_q;
        ovfl_d   = ovfl_q | (!writeN && (fcount_q == DEPTH_C) && !rd_acc);
        udfl_d   = udfl_q | (!readN && (fcount_q == '0));
        if (wr_acc && !rd_acc) begin
            fcount_d = fcount_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            fcount_d = fcount_q - CW'(1);
        end
        if (clr) begin
            fcount_d = '0;
            ovfl_d   = 1'b0;
            udfl_d   = 1'b0;
        end
        // Flags follow the next count so they move on the same edge as fcount
        empty_n_d  = (fcount_d != '0);
        full_n_d   = (fcount_d != DEPTH_C);
        aempty_n_d = (fcount_d > AEMPTY_C);
        afull_n_d  = (fcount_d < AFULL_C);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fcount_q   <= '0;
            empty_n_q  <= 1'b0;
            full_n_q   <= 1'b1;
            aempty_n_q <= 1'b0;
            afull_n_q  <= 1'b1;
            ovfl_q     <= 1'b0;
            udfl_q     <= 1'b0;
        end else begin
            fcount_q   <= fcount_d;
            empty_n_q  <= empty_n_d;
            full_n_q   <= full_n_d;
            aempty_n_q <= aempty_n_d;
            afull_n_q  <= afull_n_d;
            ovfl_q     <= ovfl_d;
            udfl_q     <= udfl_d;
        end
    end

    assign fcount    = fcount_q;
    assign F_EmptyN  = empty_n_q;
    assign F_FullN   = full_n_q;
    assign F_AEmptyN = aempty_n_q;
    assign F_AFullN  = afull_n_q;
    assign ovfl      = ovfl_q;
    assign udfl      = udfl_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: depth-8 vector table plus hand sequences for
// a depth-5 data stream and an asynchronous mid-stream reset.
module tb_fifo_ctrl;

    logic       clk;
    logic       rstN;
    logic       writeN, readN, clrN;
    logic       mw;
    logic [2:0] wa, ra;
    logic [3:0] cnt;
    logic       e_n, f_n, ae_n, af_n, ov, ud;

    logic       w5, r5, c5;
    logic       mw5;
    logic [2:0] wa5, ra5;
    logic [3:0] cnt5;
    logic       e5_n, f5_n, ae5_n, af5_n, ov5, ud5;
    logic [7:0] wdata5;
    logic [7:0] mem5 [0:7];

    int compared = 0;
    int mismatched = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_ctrl #(.FDEPTH(8), .FCWIDTH(3), .AFULL_LVL(6), .AEMPTY_LVL(2)) dut (
        .clk(clk), .rstN(rstN), .writeN(writeN), .readN(readN), .clrN(clrN),
        .mem_writeN(mw), .wr_addr(wa), .rd_addr(ra), .fcount(cnt),
        .F_EmptyN(e_n), .F_FullN(f_n), .F_AEmptyN(ae_n), .F_AFullN(af_n),
        .ovfl(ov), .udfl(ud)
    );

    fifo_ctrl #(.FDEPTH(5), .FCWIDTH(3), .AFULL_LVL(4), .AEMPTY_LVL(1)) dut5 (
        .clk(clk), .rstN(rstN), .writeN(w5), .readN(r5), .clrN(c5),
        .mem_writeN(mw5), .wr_addr(wa5), .rd_addr(ra5), .fcount(cnt5),
        .F_EmptyN(e5_n), .F_FullN(f5_n), .F_AEmptyN(ae5_n), .F_AFullN(af5_n),
        .ovfl(ov5), .udfl(ud5)
    );

    // Stand-in for the memory block behind the depth-5 controller
    always @(posedge clk) begin
        if (!mw5) mem5[wa5] <= wdata5;
    end

    typedef struct {
        logic       w, r, c;
        logic       mw;
        int         wa, ra, cnt;
        logic [3:0] fl;
        logic       ov, ud;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic w, logic r, logic c, logic m, int a, int b,
                                int n, logic [3:0] fl, logic o, logic u);
        vec_t v;
        v.w = w; v.r = r; v.c = c; v.mw = m; v.wa = a; v.ra = b; v.cnt = n;
        v.fl = fl; v.ov = o; v.ud = u;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int a, input int b, input int n,
                             input logic [3:0] fl, input logic o, input logic u);
        chk({tag, "_wr_addr"}, int'(wa), a);
        chk({tag, "_rd_addr"}, int'(ra), b);
        chk({tag, "_fcount"}, int'(cnt), n);
        chk({tag, "_flags"}, int'({e_n, f_n, ae_n, af_n}), int'(fl));
        chk({tag, "_ovfl"}, int'(ov), int'(o));
        chk({tag, "_udfl"}, int'(ud), int'(u));
        $display("%s: wr=%0d rd=%0d cnt=%0d flags=%b ovfl=%b udfl=%b",
                 tag, wa, ra, cnt, {e_n, f_n, ae_n, af_n}, ov, ud);
    endtask

    initial begin
        // flags order: {F_EmptyN, F_FullN, F_AEmptyN, F_AFullN}
        // fill 8 entries from empty
        tbl.push_back(mk(0,1,1, 0, 1,0,1, 4'b1101, 0,0));
        tbl.push_back(mk(0,1,1, 0, 2,0,2, 4'b1101, 0,0));
        tbl.push_back(mk(0,1,1, 0, 3,0,3, 4'b1111, 0,0));
        tbl.push_back(mk(0,1,1, 0, 4,0,4, 4'b1111, 0,0));
        tbl.push_back(mk(0,1,1, 0, 5,0,5, 4'b1111, 0,0));
        tbl.push_back(mk(0,1,1, 0, 6,0,6, 4'b1110, 0,0));
        tbl.push_back(mk(0,1,1, 0, 7,0,7, 4'b1110, 0,0));
        tbl.push_back(mk(0,1,1, 0, 0,0,8, 4'b1010, 0,0));
        // full: 10 simultaneous read+write, pointers wrap to 2
        tbl.push_back(mk(0,0,1, 0, 1,1,8, 4'b1010, 0,0));
        tbl.push_back(mk(0,0,1, 0, 2,2,8, 4'b1010, 0,0));
        tbl.push_back(mk(0,0,1, 0, 3,3,8, 4'b1010, 0,0));
        tbl.push_back(mk(0,0,1, 0, 4,4,8, 4'b1010, 0,0));
        tbl.push_back(mk(0,0,1, 0, 5,5,8, 4'b1010, 0,0));
        tbl.push_back(mk(0,0,1, 0, 6,6,8, 4'b1010, 0,0));
        tbl.push_back(mk(0,0,1, 0, 7,7,8, 4'b1010, 0,0));
        tbl.push_back(mk(0,0,1, 0, 0,0,8, 4'b1010, 0,0));
        tbl.push_back(mk(0,0,1, 0, 1,1,8, 4'b1010, 0,0));
        tbl.push_back(mk(0,0,1, 0, 2,2,8, 4'b1010, 0,0));
        // overflow write, sticky through idle, then flush overriding read+write
        tbl.push_back(mk(0,1,1, 1, 2,2,8, 4'b1010, 1,0));
        tbl.push_back(mk(1,1,1, 1, 2,2,8, 4'b1010, 1,0));
        tbl.push_back(mk(0,0,0, 1, 0,0,0, 4'b0101, 0,0));
        // empty: read+write -> write only, underflow; then read it back
        tbl.push_back(mk(0,0,1, 0, 1,0,1, 4'b1101, 0,1));
        tbl.push_back(mk(1,0,1, 1, 1,1,0, 4'b0101, 0,1));
        tbl.push_back(mk(1,0,1, 1, 1,1,0, 4'b0101, 0,1));
        tbl.push_back(mk(1,1,0, 1, 0,0,0, 4'b0101, 0,0));
        // build to 3, read one, write one (count 3 for the reset test)
        tbl.push_back(mk(0,1,1, 0, 1,0,1, 4'b1101, 0,0));
        tbl.push_back(mk(0,1,1, 0, 2,0,2, 4'b1101, 0,0));
        tbl.push_back(mk(0,1,1, 0, 3,0,3, 4'b1111, 0,0));
        tbl.push_back(mk(1,0,1, 1, 3,1,2, 4'b1101, 0,0));
        tbl.push_back(mk(0,1,1, 0, 4,1,3, 4'b1111, 0,0));

        rstN = 1'b0; writeN = 1'b0; readN = 1'b1; clrN = 1'b1;
        w5 = 1'b1; r5 = 1'b1; c5 = 1'b1; wdata5 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_writeN", int'(mw), 1);
        chk_state("reset", 0, 0, 0, 4'b0101, 1'b0, 1'b0);
        @(negedge clk);
        writeN = 1'b1;
        rstN = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            writeN = tbl[i].w; readN = tbl[i].r; clrN = tbl[i].c;
            #1;
            chk($sformatf("v%0d_mem_writeN", i), int'(mw), int'(tbl[i].mw));
            @(posedge clk);
            #1;
            chk_state($sformatf("v%0d", i), tbl[i].wa, tbl[i].ra, tbl[i].cnt,
                      tbl[i].fl, tbl[i].ov, tbl[i].ud);
        end
        @(negedge clk);
        writeN = 1'b1; readN = 1'b1; clrN = 1'b1;

        // depth-5 stream: pointers must run 0..4 and data must come back in order
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                w5 = 1'b0; wdata5 = 8'(rep * 16 + i);
                #1;
                chk($sformatf("d5_r%0d_wr_addr%0d", rep, i), int'(wa5), i);
                chk($sformatf("d5_r%0d_mw%0d", rep, i), int'(mw5), 0);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            w5 = 1'b1;
            chk($sformatf("d5_r%0d_full_count", rep), int'(cnt5), 5);
            chk($sformatf("d5_r%0d_full_flag", rep), int'(f5_n), 0);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                r5 = 1'b0;
                #1;
                chk($sformatf("d5_r%0d_rd_addr%0d", rep, i), int'(ra5), i);
                chk($sformatf("d5_r%0d_data%0d", rep, i), int'(mem5[ra5]), rep * 16 + i);
                $display("d5 rep%0d read %0d: addr=%0d data=%0d", rep, i, ra5, mem5[ra5]);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            r5 = 1'b1;
            chk($sformatf("d5_r%0d_empty_count", rep), int'(cnt5), 0);
            chk($sformatf("d5_r%0d_wr_wrap", rep), int'(wa5), 0);
        end

        // asynchronous reset between edges at fcount=3, with a write pending
        @(negedge clk);
        writeN = 1'b0; readN = 1'b1;
        #2;
        rstN = 1'b0;
        #1;
        chk("async_mem_writeN", int'(mw), 1);
        chk_state("async_reset", 0, 0, 0, 4'b0101, 1'b0, 1'b0);
        writeN = 1'b1;
        repeat (2) @(posedge clk);
        rstN = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
